// File: rtl/nf_uart_master.sv
// nf_uart_master: UART-to-bus bridge. Decodes 8N1 'W'/'R' command packets
// into single bus accesses and returns an ack byte or the read word on uart_tx.
module nf_uart_master #(
   parameter int WORK_FREQ  = 50_000_000,
   parameter int UART_SPEED = 115200
) (
   input  logic        clk,
   input  logic        resetn,
   output logic [31:0] addr,
   output logic        we,
   output logic [31:0] wd,
   input  logic [31:0] rd,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic        busy
);

   localparam int DIV  = WORK_FREQ / UART_SPEED;
   localparam int HALF = DIV / 2;
   localparam int CW   = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

   typedef enum logic [1:0] {
      RX_IDLE, RX_START, RX_DATA, RX_STOP
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE, TX_START, TX_DATA, TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      CMD_IDLE, CMD_ADDR, CMD_DATA, CMD_WRITE,
      CMD_RD_ADDR, CMD_RD_SAMPLE, CMD_SEND
   } cmd_state_t;

   logic          rx_s1, rx_s2, rx_d;
   rx_state_t     rx_state, rx_next;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_shift;
   logic          rx_half, rx_full;
   logic          byte_valid, frame_err;

   tx_state_t     tx_state, tx_next;
   logic [CW-1:0] tx_cnt;
   logic [2:0]    tx_bit;
   logic [31:0]   tx_buf;
   logic [1:0]    tx_left;
   logic          tx_full, tx_done;

   cmd_state_t    cmd_state, cmd_next;
   logic          is_write;
   logic [1:0]    byte_cnt;
   logic [31:0]   addr_sh, data_sh;

   assign rx_half = (rx_cnt == HALF_M1);
   assign rx_full = (rx_cnt == DIV_M1);
   assign tx_full = (tx_cnt == DIV_M1);

   // two-flop synchronizer plus one delay stage for falling-edge detection
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_d  <= 1'b1;
      end else begin
         rx_s1 <= uart_rx;
         rx_s2 <= rx_s1;
         rx_d  <= rx_s2;
      end
   end

   // receiver state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rx_state <= RX_IDLE;
      else         rx_state <= rx_next;
   end

   // receiver next state: start edge, mid-start glitch check, bits, stop
   always_comb begin
      rx_next = rx_state;
      unique case (rx_state)
         RX_IDLE:  if (rx_d && !rx_s2) rx_next = RX_START;
         RX_START: if (rx_half) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_full && rx_bit == 3'd7) rx_next = RX_STOP;
         RX_STOP:  if (rx_full) rx_next = RX_IDLE;
         default:  rx_next = RX_IDLE;
      endcase
   end

   // receiver outputs: one-cycle byte strobe or framing error at mid stop bit
   always_comb begin
      byte_valid = 1'b0;
      frame_err  = 1'b0;
      if (rx_state == RX_STOP && rx_full) begin
         byte_valid = rx_s2;
         frame_err  = !rx_s2;
      end
   end

   // receiver bit timer, bit index and LSB-first shift register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         if (rx_state == RX_IDLE || rx_next != rx_state || rx_full)
            rx_cnt <= '0;
         else
            rx_cnt <= rx_cnt + 1'b1;
         if (rx_state == RX_IDLE) begin
            rx_bit <= '0;
         end else if (rx_state == RX_DATA && rx_full) begin
            rx_bit   <= rx_bit + 1'b1;
            rx_shift <= {rx_s2, rx_shift[7:1]};
         end
      end
   end

   // transmitter state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) tx_state <= TX_IDLE;
      else         tx_state <= tx_next;
   end

   // transmitter next state: back-to-back frames while bytes remain
   always_comb begin
      tx_next = tx_state;
      unique case (tx_state)
         TX_IDLE:  if (cmd_state == CMD_SEND) tx_next = TX_START;
         TX_START: if (tx_full) tx_next = TX_DATA;
         TX_DATA:  if (tx_full && tx_bit == 3'd7) tx_next = TX_STOP;
         TX_STOP:  if (tx_full)
                      tx_next = (tx_left == 2'd0) ? TX_IDLE : TX_START;
         default:  tx_next = TX_IDLE;
      endcase
   end

   // transmitter outputs: line level and end-of-response strobe
   always_comb begin
      uart_tx = 1'b1;
      unique case (tx_state)
         TX_START: uart_tx = 1'b0;
         TX_DATA:  uart_tx = tx_buf[tx_bit];
         default:  uart_tx = 1'b1;
      endcase
      tx_done = (tx_state == TX_STOP) && tx_full && (tx_left == 2'd0);
   end

   // transmitter bit timer and bit index
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tx_cnt <= '0;
         tx_bit <= '0;
      end else begin
         if (tx_state == TX_IDLE || tx_full) tx_cnt <= '0;
         else                                tx_cnt <= tx_cnt + 1'b1;
         if (tx_state != TX_DATA) tx_bit <= '0;
         else if (tx_full)        tx_bit <= tx_bit + 1'b1;
      end
   end

   // command state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) cmd_state <= CMD_IDLE;
      else         cmd_state <= cmd_next;
   end

   // command next state; a framing error abandons a partly received packet
   always_comb begin
      cmd_next = cmd_state;
      unique case (cmd_state)
         CMD_IDLE:
            if (byte_valid && (rx_shift == 8'h57 || rx_shift == 8'h52))
               cmd_next = CMD_ADDR;
         CMD_ADDR:
            if (frame_err)
               cmd_next = CMD_IDLE;
            else if (byte_valid && byte_cnt == 2'd3)
               cmd_next = is_write ? CMD_DATA : CMD_RD_ADDR;
         CMD_DATA:
            if (frame_err)
               cmd_next = CMD_IDLE;
            else if (byte_valid && byte_cnt == 2'd3)
               cmd_next = CMD_WRITE;
         CMD_WRITE:     cmd_next = CMD_SEND;
         CMD_RD_ADDR:   cmd_next = CMD_RD_SAMPLE;
         CMD_RD_SAMPLE: cmd_next = CMD_SEND;
         CMD_SEND:      if (tx_done) cmd_next = CMD_IDLE;
         default:       cmd_next = CMD_IDLE;
      endcase
   end

   // command outputs: busy for the whole packet, write strobe only in CMD_WRITE
   always_comb begin
      busy = (cmd_state != CMD_IDLE);
      we   = (cmd_state == CMD_WRITE);
   end

   // shadows, bus registers and response buffer
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         is_write <= 1'b0;
         byte_cnt <= '0;
         addr_sh  <= '0;
         data_sh  <= '0;
         addr     <= '0;
         wd       <= '0;
         tx_buf   <= '0;
         tx_left  <= '0;
      end else begin
         if (cmd_state == CMD_IDLE) begin
            byte_cnt <= '0;
            if (byte_valid) is_write <= (rx_shift == 8'h57);
         end
         if (cmd_state == CMD_ADDR && byte_valid) begin
            byte_cnt <= byte_cnt + 1'b1;
            addr_sh  <= {rx_shift, addr_sh[31:8]};
         end
         if (cmd_state == CMD_DATA && byte_valid) begin
            byte_cnt <= byte_cnt + 1'b1;
            data_sh  <= {rx_shift, data_sh[31:8]};
         end
         if (cmd_next == CMD_RD_ADDR && cmd_state == CMD_ADDR)
            addr <= {rx_shift, addr_sh[31:8]};
         if (cmd_next == CMD_WRITE && cmd_state == CMD_DATA) begin
            addr <= addr_sh;
            wd   <= {rx_shift, data_sh[31:8]};
         end
         if (cmd_state == CMD_WRITE) begin
            tx_buf  <= 32'h0000_004B;
            tx_left <= 2'd0;
         end else if (cmd_state == CMD_RD_SAMPLE) begin
            tx_buf  <= rd;
            tx_left <= 2'd3;
         end else if (tx_state == TX_STOP && tx_full && tx_left != 2'd0) begin
            tx_buf  <= {8'h00, tx_buf[31:8]};
            tx_left <= tx_left - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_nf_uart_master.sv
// tb_nf_uart_master: directed and random packets against a queue-based
// model of the bridge, a bus slave memory and a UART line decoder.
module tb_nf_uart_master;

   localparam int DIV = 16;

   logic        clk;
   logic        resetn;
   logic [31:0] addr;
   logic        we;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        uart_rx;
   logic        uart_tx;
   logic        busy;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [31:0] we_aq[$];
   logic [31:0] we_dq[$];
   logic [7:0]  txq[$];
   logic        tx_okq[$];
   logic        tx_bzq[$];
   int          tx_tq[$];

   logic [31:0] slave_mem[logic [31:0]];
   logic [31:0] model_mem[logic [31:0]];

   nf_uart_master #(
      .WORK_FREQ (1_843_200),
      .UART_SPEED(115200)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .addr   (addr),
      .we     (we),
      .wd     (wd),
      .rd     (rd),
      .uart_rx(uart_rx),
      .uart_tx(uart_tx),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return (a == 32'h4) ? 32'hDEAD_BEEF : ~a;
   endfunction

   // bus slave: registered read, write on strobe
   always @(posedge clk)
      rd <= slave_mem.exists(addr) ? slave_mem[addr] : dflt(addr);

   always @(negedge clk) begin
      if (we === 1'b1) begin
         we_aq.push_back(addr);
         we_dq.push_back(wd);
         slave_mem[addr] = wd;
      end
   end

   // line decoder for uart_tx
   initial begin : tx_decoder
      bit prev;
      logic [7:0] b;
      logic ok;
      int t0;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (prev && uart_tx === 1'b0) begin
            t0 = cyc;
            repeat (DIV / 2) @(negedge clk);
            ok = (uart_tx === 1'b0);
            for (int i = 0; i < 8; i++) begin
               repeat (DIV) @(negedge clk);
               b[i] = uart_tx;
            end
            repeat (DIV) @(negedge clk);
            ok = ok && (uart_tx === 1'b1);
            txq.push_back(b);
            tx_okq.push_back(ok);
            tx_bzq.push_back(busy);
            tx_tq.push_back(t0);
         end
         prev = uart_tx;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(negedge clk);
      uart_rx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (DIV) @(negedge clk);
      end
      uart_rx = stop_bit;
      repeat (DIV) @(negedge clk);
      uart_rx = 1'b1;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
   endtask

   task automatic expect_tx(input logic [31:0] v, input int n,
                            input string tag);
      int budget;
      int tprev;
      int t;
      budget = (n * 10 + 12) * DIV;
      while (txq.size() < n && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      chk({tag, "_count"}, 32'(txq.size()), 32'(n));
      tprev = 0;
      for (int i = 0; i < n; i++) begin
         if (txq.size() > 0) begin
            chk($sformatf("%s_byte%0d", tag, i), 32'(txq.pop_front()),
                32'(v[8*i +: 8]));
            chk($sformatf("%s_frame%0d", tag, i), 32'(tx_okq.pop_front()),
                32'd1);
            chk($sformatf("%s_busy%0d", tag, i), 32'(tx_bzq.pop_front()),
                32'd1);
            t = tx_tq.pop_front();
            if (i > 0)
               chk($sformatf("%s_gap%0d", tag, i), 32'(t - tprev),
                   32'(10 * DIV));
            tprev = t;
         end
      end
      budget = DIV;
      while (busy !== 1'b0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d);
      int n0;
      n0 = we_aq.size();
      send_byte(8'h57, 1'b1);
      send_word(a);
      send_word(d);
      expect_tx(32'h4B, 1, "wr_ack");
      chk("wr_we_count", 32'(we_aq.size()), 32'(n0 + 1));
      if (we_aq.size() > n0) begin
         chk("wr_addr", we_aq[n0], a);
         chk("wr_wd", we_dq[n0], d);
      end
      model_mem[a] = d;
   endtask

   task automatic do_read(input logic [31:0] a);
      int n0;
      logic [31:0] e;
      n0 = we_aq.size();
      e = model_mem.exists(a) ? model_mem[a] : dflt(a);
      send_byte(8'h52, 1'b1);
      send_word(a);
      expect_tx(e, 4, "rd");
      chk("rd_no_we", 32'(we_aq.size()), 32'(n0));
   endtask

   initial begin : stim
      int n0;
      int budget;
      logic [31:0] a;
      logic [31:0] d;

      resetn  = 1'b0;
      uart_rx = 1'b1;
      idle(5);
      chk("rst_tx", 32'(uart_tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_addr", addr, 32'h0);
      chk("rst_wd", wd, 32'h0);
      resetn = 1'b1;
      idle(4);

      do_write(32'h0000_0010, 32'h1234_5678);
      do_read(32'h0000_0004);

      n0 = we_aq.size();
      send_byte(8'h00, 1'b1);
      chk("junk00_busy", 32'(busy), 32'd0);
      send_byte(8'hFF, 1'b1);
      chk("junkff_busy", 32'(busy), 32'd0);
      send_byte(8'h41, 1'b1);
      chk("junk41_busy", 32'(busy), 32'd0);
      do_write(32'h0000_0030, $urandom);
      chk("junk_we_total", 32'(we_aq.size()), 32'(n0 + 1));

      n0 = we_aq.size();
      send_byte(8'h57, 1'b1);
      send_byte(8'h10, 1'b1);
      send_byte(8'h00, 1'b0);
      idle(DIV);
      chk("ferr_busy", 32'(busy), 32'd0);
      do_write(32'h0000_0020, $urandom);
      chk("ferr_we_total", 32'(we_aq.size()), 32'(n0 + 1));

      @(negedge clk);
      uart_rx = 1'b0;
      idle(5);
      uart_rx = 1'b1;
      idle(2 * DIV);
      chk("glitch_busy", 32'(busy), 32'd0);
      chk("glitch_no_tx", 32'(txq.size()), 32'd0);
      do_read(32'h0000_0010);

      for (int k = 0; k < 5; k++) begin
         a = $urandom & 32'hFFFF_FFFC;
         d = $urandom;
         if ($urandom_range(0, 1) == 1) do_write(a, d);
         do_read(a);
      end

      send_byte(8'h52, 1'b1);
      send_word(32'h0000_0004);
      budget = 16 * DIV;
      while (txq.size() < 1 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      chk("rstmid_first", 32'(txq.size()), 32'd1);
      idle(2 * DIV);
      resetn = 1'b0;
      #1;
      chk("rstmid_tx", 32'(uart_tx), 32'd1);
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_we", 32'(we), 32'd0);
      chk("rstmid_addr", addr, 32'h0);
      idle(12 * DIV);
      txq.delete();
      tx_okq.delete();
      tx_bzq.delete();
      tx_tq.delete();
      resetn = 1'b1;
      idle(4);
      a = ($urandom & 32'h0000_FFFC) | 32'h0001_0000;
      do_write(a, $urandom);
      do_read(a);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
